// File: rtl/pixel_gen_pkg.sv
// pixel_gen_pkg: shared sizes and AXI-Lite constants for the pixel generator
package pixel_gen_pkg;
  localparam int X_SIZE_DEF = 640;
  localparam int Y_SIZE_DEF = 480;
  localparam int REG_COUNT = 8;
  localparam int DATA_W = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/pixel_generator_axi_lite_regs.sv
// axi_lite_regs: AXI-Lite slave with eight read/write registers, one transaction per channel
module axi_lite_regs
  import pixel_gen_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_W-1:0]                 awaddr,
  input  logic                              awvalid,
  output logic                              awready,
  input  logic [DATA_W-1:0]                 wdata,
  input  logic                              wvalid,
  output logic                              wready,
  output logic [1:0]                        bresp,
  output logic                              bvalid,
  input  logic                              bready,
  input  logic [ADDR_W-1:0]                 araddr,
  input  logic                              arvalid,
  output logic                              arready,
  output logic [DATA_W-1:0]                 rdata,
  output logic [1:0]                        rresp,
  output logic                              rvalid,
  input  logic                              rready,
  output logic [REG_COUNT-1:0][DATA_W-1:0]  regs
);
  localparam int IW = $clog2(REG_COUNT);
  logic wr_hs, rd_hs, wr_ok, rd_ok, wr_go, unused_addr;
  assign wr_go = awvalid & wvalid & ~bvalid & ~awready;
  assign wr_hs = awready & awvalid & wready & wvalid;
  assign rd_hs = arready & arvalid;
  assign wr_ok = awaddr < ADDR_W'(REG_COUNT * 4);
  assign rd_ok = araddr < ADDR_W'(REG_COUNT * 4);
  assign bresp = RESP_OKAY;
  assign rresp = RESP_OKAY;
  assign unused_addr = ^{awaddr[1:0], araddr[1:0]};
  // Reads sample regs before a same-edge write lands, so a colliding read sees the old value
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      regs    <= '0;
    end else begin
      awready <= wr_go;
      wready  <= wr_go;
      if (wr_hs && wr_ok) regs[awaddr[IW+1:2]] <= wdata;
      bvalid  <= wr_hs | (bvalid & ~bready);
      arready <= arvalid & ~rvalid & ~arready;
      if (rd_hs) rdata <= rd_ok ? regs[araddr[IW+1:2]] : '0;
      rvalid  <= rd_hs | (rvalid & ~rready);
    end
endmodule

// File: rtl/pixel_generator.sv
// pixel_generator: raster test-pattern AXI-Stream source, blue channel from register 0 per frame
module pixel_generator
  import pixel_gen_pkg::*;
#(
  parameter int AXI_LITE_ADDR_WIDTH = 8,
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF
) (
  input  logic                           out_stream_aclk,
  input  logic                           periph_reset,
  output logic [31:0]                    out_stream_tdata,
  output logic [3:0]                     out_stream_tkeep,
  output logic                           out_stream_tlast,
  input  logic                           out_stream_tready,
  output logic                           out_stream_tvalid,
  output logic                           out_stream_tuser,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                           s_axi_lite_awvalid,
  output logic                           s_axi_lite_awready,
  input  logic [31:0]                    s_axi_lite_wdata,
  input  logic                           s_axi_lite_wvalid,
  output logic                           s_axi_lite_wready,
  output logic [1:0]                     s_axi_lite_bresp,
  output logic                           s_axi_lite_bvalid,
  input  logic                           s_axi_lite_bready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                           s_axi_lite_arvalid,
  output logic                           s_axi_lite_arready,
  output logic [31:0]                    s_axi_lite_rdata,
  output logic [1:0]                     s_axi_lite_rresp,
  output logic                           s_axi_lite_rvalid,
  input  logic                           s_axi_lite_rready
);
  localparam int XW = $clog2(X_SIZE) > 8 ? $clog2(X_SIZE) : 8;
  localparam int YW = $clog2(Y_SIZE) > 8 ? $clog2(Y_SIZE) : 8;
  logic [REG_COUNT-1:0][DATA_W-1:0] regs;
  logic [7:0] frame_reg0, b;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic load, sof, eol, eof, unused_regs;
  axi_lite_regs #(.ADDR_W(AXI_LITE_ADDR_WIDTH)) u_regs (
    .clk(out_stream_aclk), .rst(periph_reset),
    .awaddr(s_axi_lite_awaddr), .awvalid(s_axi_lite_awvalid), .awready(s_axi_lite_awready),
    .wdata(s_axi_lite_wdata), .wvalid(s_axi_lite_wvalid), .wready(s_axi_lite_wready),
    .bresp(s_axi_lite_bresp), .bvalid(s_axi_lite_bvalid), .bready(s_axi_lite_bready),
    .araddr(s_axi_lite_araddr), .arvalid(s_axi_lite_arvalid), .arready(s_axi_lite_arready),
    .rdata(s_axi_lite_rdata), .rresp(s_axi_lite_rresp), .rvalid(s_axi_lite_rvalid),
    .rready(s_axi_lite_rready), .regs(regs)
  );
  assign unused_regs = ^regs;
  assign out_stream_tkeep = 4'hF;
  assign load = ~out_stream_tvalid | out_stream_tready;
  assign sof = x == '0 && y == '0;
  assign eol = x == XW'(X_SIZE - 1);
  assign eof = y == YW'(Y_SIZE - 1);
  // The (0,0) beat takes register 0 directly so the whole frame shares the value latched with it
  assign b = sof ? regs[0][7:0] : frame_reg0;
  always_ff @(posedge out_stream_aclk or posedge periph_reset)
    if (periph_reset) begin
      out_stream_tvalid <= 1'b0;
      out_stream_tdata  <= '0;
      out_stream_tuser  <= 1'b0;
      out_stream_tlast  <= 1'b0;
      frame_reg0        <= '0;
      x                 <= '0;
      y                 <= '0;
    end else if (load) begin
      out_stream_tvalid <= 1'b1;
      out_stream_tdata  <= {8'h00, x[7:0], y[7:0], b};
      out_stream_tuser  <= sof;
      out_stream_tlast  <= eol;
      frame_reg0        <= b;
      x                 <= eol ? '0 : x + XW'(1);
      y                 <= eol ? (eof ? '0 : y + YW'(1)) : y;
    end
endmodule

// File: tb/tb_pixel_generator.sv
// tb_pixel_generator: scoreboarded stream checks plus table-driven AXI-Lite register vectors
module tb_pixel_generator;
  localparam int XS = 8;
  localparam int YS = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast, out_stream_tready, out_stream_tvalid, out_stream_tuser;
  logic [7:0]  s_axi_lite_awaddr, s_axi_lite_araddr;
  logic        s_axi_lite_awvalid, s_axi_lite_awready, s_axi_lite_wvalid, s_axi_lite_wready;
  logic [31:0] s_axi_lite_wdata, s_axi_lite_rdata;
  logic [1:0]  s_axi_lite_bresp, s_axi_lite_rresp;
  logic        s_axi_lite_bvalid, s_axi_lite_bready, s_axi_lite_arvalid, s_axi_lite_arready;
  logic        s_axi_lite_rvalid, s_axi_lite_rready;

  always #5 clk = ~clk;

  pixel_generator #(.AXI_LITE_ADDR_WIDTH(8), .X_SIZE(XS), .Y_SIZE(YS)) dut (
    .out_stream_aclk(clk), .periph_reset(rst),
    .out_stream_tdata(out_stream_tdata), .out_stream_tkeep(out_stream_tkeep),
    .out_stream_tlast(out_stream_tlast), .out_stream_tready(out_stream_tready),
    .out_stream_tvalid(out_stream_tvalid), .out_stream_tuser(out_stream_tuser),
    .s_axi_lite_awaddr(s_axi_lite_awaddr), .s_axi_lite_awvalid(s_axi_lite_awvalid),
    .s_axi_lite_awready(s_axi_lite_awready), .s_axi_lite_wdata(s_axi_lite_wdata),
    .s_axi_lite_wvalid(s_axi_lite_wvalid), .s_axi_lite_wready(s_axi_lite_wready),
    .s_axi_lite_bresp(s_axi_lite_bresp), .s_axi_lite_bvalid(s_axi_lite_bvalid),
    .s_axi_lite_bready(s_axi_lite_bready), .s_axi_lite_araddr(s_axi_lite_araddr),
    .s_axi_lite_arvalid(s_axi_lite_arvalid), .s_axi_lite_arready(s_axi_lite_arready),
    .s_axi_lite_rdata(s_axi_lite_rdata), .s_axi_lite_rresp(s_axi_lite_rresp),
    .s_axi_lite_rvalid(s_axi_lite_rvalid), .s_axi_lite_rready(s_axi_lite_rready)
  );

  int n_cmp = 0, n_bad = 0;
  logic [37:0] q[$];
  int mx, my;
  logic [7:0] mb, m_reg0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected beat = {tkeep, tuser, tlast, tdata}; blue is captured when (0,0) is queued
  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) begin
      logic s, l;
      logic [7:0] xb, yb;
      s = (mx == 0 && my == 0);
      l = (mx == XS - 1);
      xb = 8'(mx);
      yb = 8'(my);
      if (s) mb = m_reg0;
      q.push_back({4'hF, s, l, 8'h00, xb, yb, mb});
      mx++;
      if (mx == XS) begin
        mx = 0;
        my = (my == YS - 1) ? 0 : my + 1;
      end
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mb = 8'h00; m_reg0 = 8'h00;
  endtask

  task automatic drain(input bit rnd);
    int t = 0;
    while (q.size() != 0 && t < 2000) begin
      out_stream_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      t++;
    end
    out_stream_tready = 1'b0;
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d beats left, expected 0", q.size());
      q.delete();
    end
  endtask

  logic [37:0] obs, obs_p, e;
  logic stall_p = 1'b0;
  assign obs = {out_stream_tkeep, out_stream_tuser, out_stream_tlast, out_stream_tdata};
  always @(negedge clk) begin
    if (rst) stall_p <= 1'b0;
    else begin
      if (stall_p) chk("stall_hold", 64'(obs), 64'(obs_p));
      if (out_stream_tvalid && out_stream_tready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL beat_extra: got %h expected no beat", obs);
        end else begin
          e = q.pop_front();
          chk("beat", 64'(obs), 64'(e));
        end
      end
      stall_p <= out_stream_tvalid & ~out_stream_tready;
      obs_p <= obs;
    end
  end

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
    int t = 0;
    s_axi_lite_awaddr = a; s_axi_lite_awvalid = 1'b1;
    s_axi_lite_wdata = d;  s_axi_lite_wvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!(s_axi_lite_awready && s_axi_lite_wready) && t < 100);
    chk("aw_w_ready", {s_axi_lite_awready, s_axi_lite_wready}, 2'b11);
    @(posedge clk); #1;
    s_axi_lite_awvalid = 1'b0; s_axi_lite_wvalid = 1'b0; s_axi_lite_bready = 1'b1;
    @(negedge clk);
    chk("bvalid_bresp", {s_axi_lite_bvalid, s_axi_lite_bresp}, 3'b100);
    @(posedge clk); #1;
    s_axi_lite_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
    int t = 0;
    s_axi_lite_araddr = a; s_axi_lite_arvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!s_axi_lite_arready && t < 100);
    chk("arready", s_axi_lite_arready, 1'b1);
    @(posedge clk); #1;
    s_axi_lite_arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_rresp", {s_axi_lite_rvalid, s_axi_lite_rresp}, 3'b100);
    d = s_axi_lite_rdata;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdata_hold", {s_axi_lite_rvalid, s_axi_lite_rdata}, {1'b1, d});
    s_axi_lite_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_lite_rready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } axi_vec_t;
  axi_vec_t tbl[9];

  initial begin
    logic [31:0] rd;
    out_stream_tready = 1'b0;
    s_axi_lite_awaddr = '0; s_axi_lite_awvalid = 1'b0; s_axi_lite_wdata = '0;
    s_axi_lite_wvalid = 1'b0; s_axi_lite_bready = 1'b0; s_axi_lite_araddr = '0;
    s_axi_lite_arvalid = 1'b0; s_axi_lite_rready = 1'b0;
    tbl[0] = '{1'b1, 8'h1C, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 8'h1C, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 8'h40, 32'h00000000};
    tbl[3] = '{1'b1, 8'h44, 32'h12345678};
    tbl[4] = '{1'b0, 8'h04, 32'h00000000};
    tbl[5] = '{1'b1, 8'h0B, 32'h000000A5};
    tbl[6] = '{1'b0, 8'h08, 32'h000000A5};
    tbl[7] = '{1'b0, 8'h00, 32'h00000005};
    tbl[8] = '{1'b0, 8'h1F, 32'hDEADBEEF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stream", {out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata}, '0);
    chk("reset_axi", {s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready,
                      s_axi_lite_bvalid, s_axi_lite_rvalid, s_axi_lite_bresp,
                      s_axi_lite_rresp, s_axi_lite_rdata}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tvalid_before_edge", out_stream_tvalid, 1'b0);
    @(negedge clk);
    chk("tvalid_rise", out_stream_tvalid, 1'b1);
    @(posedge clk); #1;
    model_reset();
    push_beats(XS * YS + 1);
    drain(1'b0);

    axi_write(8'h00, 32'h00000005);
    m_reg0 = 8'h05;
    push_beats(39);
    drain(1'b1);

    foreach (tbl[i]) begin
      if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data);
      else begin
        axi_read(tbl[i].addr, rd);
        chk($sformatf("reg_read_%02h", tbl[i].addr), rd, tbl[i].data);
      end
    end
    fork
      axi_write(8'h08, 32'h00005A5A);
      axi_read(8'h08, rd);
    join
    chk("rd_wr_collide_old", rd, 32'h000000A5);
    axi_read(8'h08, rd);
    chk("rd_after_collide", rd, 32'h00005A5A);

    rst = 1'b1;
    @(negedge clk);
    chk("reset_resync", {out_stream_tvalid, out_stream_tdata}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    push_beats(13);
    drain(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_at_beat13", {out_stream_tvalid, out_stream_tuser, out_stream_tdata}, '0);
    @(negedge clk);
    chk("reset_hold_tvalid", out_stream_tvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    push_beats(10);
    drain(1'b0);
    axi_read(8'h1C, rd);
    chk("reg_cleared_by_reset", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pixel_generator.md
PIXEL_GENERATOR -- requirements
Module: pixel_generator

Interface
REQ-001 Parameters SHALL be: AXI_LITE_ADDR_WIDTH, default 8, AXI-Lite byte-address width; X_SIZE, default 640, pixels per line; Y_SIZE, default 480, lines per frame.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset ports are permitted.
REQ-003 Ports SHALL be:
- out_stream_aclk, in, 1: sole clock for stream and AXI-Lite logic.
- periph_reset, in, 1: asynchronous active-high reset.
- out_stream_tdata, out, 32: pixel {8'h00,R,G,B}.
- out_stream_tkeep, out, 4: byte enables.
- out_stream_tlast, out, 1: end of line.
- out_stream_tready, in, 1: sink ready.
- out_stream_tvalid, out, 1: beat valid.
- out_stream_tuser, out, 1: start of frame.
- s_axi_lite_awaddr, in, AXI_LITE_ADDR_WIDTH; s_axi_lite_awvalid, in, 1; s_axi_lite_awready, out, 1.
- s_axi_lite_wdata, in, 32; s_axi_lite_wvalid, in, 1; s_axi_lite_wready, out, 1.
- s_axi_lite_bresp, out, 2; s_axi_lite_bvalid, out, 1; s_axi_lite_bready, in, 1.
- s_axi_lite_araddr, in, AXI_LITE_ADDR_WIDTH; s_axi_lite_arvalid, in, 1; s_axi_lite_arready, out, 1.
- s_axi_lite_rdata, out, 32; s_axi_lite_rresp, out, 2; s_axi_lite_rvalid, out, 1; s_axi_lite_rready, in, 1.

Function
REQ-004 The block SHALL generate frames in raster order (x 0..X_SIZE-1, then y 0..Y_SIZE-1), one pixel per stream beat, wrapping from (X_SIZE-1,Y_SIZE-1) to (0,0) indefinitely.
REQ-005 Pixel colour SHALL be R=x[7:0], G=y[7:0], B=frame_reg0[7:0], giving tdata={8'h00,R,G,B}.
REQ-006 tkeep SHALL be constant 4'hF.
REQ-007 tuser SHALL be 1 only on the beat with x=0, y=0.
REQ-008 tlast SHALL be 1 only on beats with x=X_SIZE-1.
REQ-009 All stream outputs SHALL be registered.
REQ-010 tvalid SHALL rise on the first clock edge after reset release and SHALL then stay high continuously.
REQ-011 A beat SHALL transfer on tvalid&tready.
REQ-012 While tready=0, tdata, tlast and tuser SHALL hold stable and the x/y counters SHALL not advance.
REQ-013 With tready held 1, the block SHALL sustain one beat per clock with no bubbles, including across line and frame boundaries.
REQ-014 frame_reg0 SHALL be a copy of register 0, latched when the (0,0) beat is loaded into the output register, so a frame never mixes two B values.
REQ-015 The register file SHALL hold 8 x 32-bit read/write registers at byte offsets 0x00..0x1C, indexed by addr[4:2]; addr[1:0] is ignored.
REQ-016 Writes and reads to addresses >= 0x20 SHALL be accepted with response OKAY; such writes have no effect and such reads return 0.
REQ-017 Write handshake: awready and wready SHALL pulse together for one cycle when awvalid and wvalid are both high and bvalid is low.
REQ-018 On a write, the register SHALL update on that edge and bvalid SHALL assert the next cycle with bresp=2'b00, holding until bready.
REQ-019 Read handshake: arready SHALL pulse for one cycle when arvalid=1 and rvalid=0.
REQ-020 On a read, rvalid SHALL assert the next cycle with rdata and rresp=2'b00, holding stable until rready.
REQ-021 Only one transaction per channel SHALL be outstanding at a time.
REQ-022 A simultaneous read and write to the same register SHALL return the old value.

Reset
REQ-023 Reset SHALL force: tvalid=0, tdata=0, tuser=0, tlast=0, x=y=0, all registers and frame_reg0 =0, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release, the next frame SHALL start at (0,0) with tuser=1.

Structure
REQ-025 Package pixel_gen_pkg SHALL hold default X_SIZE/Y_SIZE, register count (8), data width (32), and the OKAY response constant.
REQ-026 The AXI-Lite slave and register file SHALL be a sub-module axi_lite_regs that exports all 8 registers; pixel_generator holds the counters and stream logic.

Verification
REQ-027 With X_SIZE=8, Y_SIZE=4 and tready=1 after reset release: beat 0 = 0x00000000 with tuser=1; beat 7 = 0x00070000 with tlast=1; beat 31 = 0x00070300 with tlast=1; beat 32 = 0x00000000 with tuser=1.
REQ-028 Write 0x05 to offset 0x00 mid-frame: bvalid with bresp=0 is seen; current frame keeps B=0x00; the next frame's beats have B=0x05 (beat 0 = 0x00000005).
REQ-029 Randomly toggle tready: the transferred beat sequence is identical to the tready=1 case, and tdata is stable throughout every stall.
REQ-030 Write 0xDEADBEEF to 0x1C then read 0x1C, which returns 0xDEADBEEF; read 0x40, which returns 0 with rresp=0.
REQ-031 Assert reset at beat 13 and release it: tvalid=0 during reset, and the first beat after release is 0x00000000 with tuser=1.
